reg_file: RTL and testbench

32-entry × 32-bit general-purpose register file for the pipelined processor's decode stage. It has two read ports and one write port. Writes commit on the rising clock edge. Reads are registered on the falling edge, so a value written in the first half of a cycle is visible on the read outputs at the end of that same cycle. Reset preloads every register with its own index, giving a known, self-identifying state for bring-up and test.

---
 rtl/reg_file.sv | 72 +++++++
 tb/tb_reg_file.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit register file with two read ports and one write port.
// Writes land on the rising edge. The read ports register on the falling edge,
// so a value written at the rising edge is already visible half a cycle later.
// Reset preloads every register with its own index and clears both read outputs.
// Optional build macro REG_FILE_ZERO_REG_EN makes register 0 a hardwired zero.

module reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [4:0]  PR1,
    input  logic [4:0]  PR2,
    input  logic [4:0]  WR,
    input  logic [31:0] WD,
    output logic [31:0] RD1,
    output logic [31:0] RD2
);

    localparam int unsigned NumRegs = 32;

    logic [31:0] rf_mem [NumRegs];
    logic        wr_en;
    logic [31:0] rd1_d;
    logic [31:0] rd2_d;

    // Qualify the write strobe; an X/Z strobe never evaluates true, so it is a no-op.
    always_comb begin
        wr_en = 1'b0;
`ifdef REG_FILE_ZERO_REG_EN
        wr_en = (write == 1'b1) && (WR != 5'd0);
`else
        wr_en = (write == 1'b1);
`endif
    end

    // Storage: index pattern on reset, otherwise commit the write on the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NumRegs; i++) begin
                rf_mem[i] <= 32'(i);
            end
        end else if (wr_en) begin
            rf_mem[WR] <= WD;
        end
    end

    // Read-port lookup; register 0 forced to zero when the zero register is enabled.
    always_comb begin
        rd1_d = rf_mem[PR1];
        rd2_d = rf_mem[PR2];
`ifdef REG_FILE_ZERO_REG_EN
        if (PR1 == 5'd0) begin
            rd1_d = 32'd0;
        end
        if (PR2 == 5'd0) begin
            rd2_d = 32'd0;
        end
`endif
    end

    // Read registers load on the falling edge, giving write-before-read in one cycle.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            RD1 <= 32'd0;
            RD2 <= 32'd0;
        end else begin
            RD1 <= rd1_d;
            RD2 <= rd2_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a randomized run
// against an array-based reference model of the register contents.

module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [4:0]  PR1;
    logic [4:0]  PR2;
    logic [4:0]  WR;
    logic [31:0] WD;
    logic [31:0] RD1;
    logic [31:0] RD2;

    logic [31:0] model [32];
    int errors = 0;
    int checks = 0;

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .write (write),
        .PR1   (PR1),
        .PR2   (PR2),
        .WR    (WR),
        .WD    (WD),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
`ifdef REG_FILE_ZERO_REG_EN
        if (idx == 5'd0) return 32'd0;
`endif
        return model[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = i;
    endtask

    // Apply this cycle's write to the model (reset assumed low).
    task automatic model_write();
        if (write === 1'b1) begin
`ifdef REG_FILE_ZERO_REG_EN
            if (WR != 5'd0) model[WR] = WD;
`else
            model[WR] = WD;
`endif
        end
    endtask

    // One full cycle from just after a falling edge to just after the next one.
    task automatic step();
        @(posedge clk);
        model_write();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; write = 1'b0; PR1 = 5'd0; PR2 = 5'd0; WR = 5'd0; WD = 32'd0;
        #2;
        checks++; if (RD1 !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h want %h", RD1, 32'd0); end
        checks++; if (RD2 !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h want %h", RD2, 32'd0); end
        @(negedge clk); #1;
        checks++; if (RD1 !== 32'd0) begin errors++; $display("FAIL reset_hold_rd1 got %h want %h", RD1, 32'd0); end
        reset = 1'b0; PR1 = 5'd6; PR2 = 5'd8;
        model_reset();
        step();
        checks++; if (RD1 !== 32'd6) begin errors++; $display("FAIL preset_rd1 got %h want %h", RD1, 32'd6); end
        checks++; if (RD2 !== 32'd8) begin errors++; $display("FAIL preset_rd2 got %h want %h", RD2, 32'd8); end
    endtask

    task automatic test_write_read();
        write = 1'b1; WR = 5'd4; WD = 32'd31;
        step();
        write = 1'b0; PR1 = 5'd4;
        step();
        checks++; if (RD1 !== 32'd31) begin errors++; $display("FAIL wr_rd1 got %h want %h", RD1, 32'd31); end
        checks++; if (RD2 !== 32'd8) begin errors++; $display("FAIL wr_rd2 got %h want %h", RD2, 32'd8); end
    endtask

    task automatic test_mid_reset();
        #3;
        reset = 1'b1;
        #1;
        checks++; if (RD1 !== 32'd0) begin errors++; $display("FAIL midrst_rd1 got %h want %h", RD1, 32'd0); end
        checks++; if (RD2 !== 32'd0) begin errors++; $display("FAIL midrst_rd2 got %h want %h", RD2, 32'd0); end
        // Write pending at a rising edge during reset must be discarded.
        write = 1'b1; WR = 5'd4; WD = 32'h1234_5678;
        @(posedge clk); #1;
        @(negedge clk); #1;
        reset = 1'b0; write = 1'b0; PR1 = 5'd10; PR2 = 5'd12;
        model_reset();
        step();
        checks++; if (RD1 !== 32'd10) begin errors++; $display("FAIL rel_rd1 got %h want %h", RD1, 32'd10); end
        checks++; if (RD2 !== 32'd12) begin errors++; $display("FAIL rel_rd2 got %h want %h", RD2, 32'd12); end
        PR1 = 5'd4;
        step();
        checks++; if (RD1 !== 32'd4) begin errors++; $display("FAIL restore_r4 got %h want %h", RD1, 32'd4); end
    endtask

    task automatic test_same_cycle();
        write = 1'b1; WR = 5'd1; WD = 32'd20; PR1 = 5'd7;
        @(posedge clk);
        model_write();
        #1;
        write = 1'b0; PR1 = 5'd1;
        @(negedge clk); #1;
        checks++; if (RD1 !== 32'd20) begin errors++; $display("FAIL same_cycle got %h want %h", RD1, 32'd20); end
    endtask

    task automatic test_hold();
        write = 1'b0; PR1 = 5'd2;
        step();
        checks++; if (RD1 !== 32'd2) begin errors++; $display("FAIL hold_base got %h want %h", RD1, 32'd2); end
        PR1 = 5'd5;
        #2;
        checks++; if (RD1 !== 32'd2) begin errors++; $display("FAIL hold_mid got %h want %h", RD1, 32'd2); end
        @(posedge clk); #1;
        checks++; if (RD1 !== 32'd2) begin errors++; $display("FAIL hold_rise got %h want %h", RD1, 32'd2); end
        @(negedge clk); #1;
        checks++; if (RD1 !== 32'd5) begin errors++; $display("FAIL hold_next got %h want %h", RD1, 32'd5); end
    endtask

    task automatic test_write_disabled();
        write = 1'b0; WR = 5'd3; WD = 32'hDEAD_BEEF;
        repeat (3) step();
        PR1 = 5'd3;
        step();
        checks++; if (RD1 !== 32'd3) begin errors++; $display("FAIL wr_disabled got %h want %h", RD1, 32'd3); end
    endtask

    task automatic test_write_x();
        write = 1'bx; WR = 5'd5; WD = 32'hCAFE_F00D;
        step();
        write = 1'b0; PR2 = 5'd5;
        step();
        checks++; if (RD2 !== ref_read(5'd5)) begin errors++; $display("FAIL wr_x got %h want %h", RD2, ref_read(5'd5)); end
    endtask

    task automatic test_zero_reg();
        logic [31:0] exp0;
`ifdef REG_FILE_ZERO_REG_EN
        exp0 = 32'd0;
`else
        exp0 = 32'd55;
`endif
        write = 1'b1; WR = 5'd0; WD = 32'd55;
        step();
        write = 1'b0; PR1 = 5'd0; PR2 = 5'd0;
        step();
        checks++; if (RD2 !== exp0) begin errors++; $display("FAIL zero_rd2 got %h want %h", RD2, exp0); end
        checks++; if (RD1 !== exp0) begin errors++; $display("FAIL zero_rd1 got %h want %h", RD1, exp0); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            write = ($urandom_range(0, 2) != 0);
            WR    = 5'($urandom_range(0, 31));
            WD    = $urandom;
            PR1   = 5'($urandom_range(0, 31));
            PR2   = ($urandom_range(0, 3) == 0) ? PR1 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) PR1 = WR;
            step();
            checks++; if (RD1 !== ref_read(PR1)) begin errors++; $display("FAIL rand_rd1 n=%0d pr1=%0d got %h want %h", n, PR1, RD1, ref_read(PR1)); end
            checks++; if (RD2 !== ref_read(PR2)) begin errors++; $display("FAIL rand_rd2 n=%0d pr2=%0d got %h want %h", n, PR2, RD2, ref_read(PR2)); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_mid_reset();
        test_same_cycle();
        test_hold();
        test_write_disabled();
        test_write_x();
        test_zero_reg();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
